wav_apb_initiator: RTL and testbench

APB3 initiator that converts single register read/write commands from a valid/ready command port into APB transfers toward a generated register block. It sits between a host-side controller (debug port, sequencer, CPU shim) and any `*_regs_top` completer, and returns read data, `PSLVERR`, and a timeout flag on a valid/ready response port. Exactly one transfer is outstanding at a time.

---
 rtl/wav_apb_pkg.sv | 35 +++
 rtl/wav_apb_timeout_cnt.sv | 59 +++++
 rtl/wav_apb_initiator.sv | 152 +++++++++++++++
 tb/tb_wav_apb_initiator.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wav_apb_pkg.sv
// -----------------------------------------------------------------------------
// wav_apb_pkg
// Shared types for the APB3 initiator.
//   apb_state_t    : initiator FSM state (IDLE, SETUP, ACCESS, RESP), 2-bit.
//   APB_DATA_WIDTH : APB data bus width.
//   apb_rsp_t      : registered response fields returned to the host.
//   timeout_rsp()  : response value used when the completer never answers.
// -----------------------------------------------------------------------------
package wav_apb_pkg;

    localparam int APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    typedef struct packed {
        logic [APB_DATA_WIDTH-1:0] rdata;
        logic                      err;
        logic                      timeout;
    } apb_rsp_t;

    // An aborted transfer reports an error with no data.
    function automatic apb_rsp_t timeout_rsp();
        apb_rsp_t r;
        r.rdata   = '0;
        r.err     = 1'b1;
        r.timeout = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/wav_apb_timeout_cnt.sv
// -----------------------------------------------------------------------------
// wav_apb_timeout_cnt
// Saturating cycle counter that flags when an APB ACCESS phase has run for
// MAX cycles without completion. MAX = 0 removes the counter entirely.
// Ports:
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   clr     : synchronous clear (new transfer accepted)
//   en      : count enable (ACCESS cycle with PREADY low)
//   expired : counter holds MAX-1, i.e. this is the last allowed ACCESS cycle
// -----------------------------------------------------------------------------
module wav_apb_timeout_cnt #(
    parameter int unsigned MAX = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    generate
        if (MAX == 0) begin : g_off
            // Timeout disabled: no state, inputs intentionally unused.
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst_n, clr, en};
            assign expired       = 1'b0;
        end else begin : g_cnt
            localparam int unsigned W    = $clog2(MAX + 1);
            localparam logic [W-1:0] LAST = W'(MAX - 1);
            localparam logic [W-1:0] TOP  = W'(MAX);

            logic [W-1:0] cnt_q;
            logic [W-1:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clr) begin
                    cnt_d = '0;
                end else if (en && (cnt_q != TOP)) begin
                    cnt_d = cnt_q + W'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            // The counter reads k during the (k+1)-th ACCESS cycle, so matching
            // MAX-1 bounds ACCESS to exactly MAX cycles.
            assign expired = (cnt_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/wav_apb_initiator.sv
// -----------------------------------------------------------------------------
// wav_apb_initiator
// APB3 initiator: turns single read/write commands from a valid/ready command
// port into APB transfers and returns read data, PSLVERR and a timeout flag on
// a valid/ready response port. One transfer is outstanding at a time.
// Ports:
//   RegClk, RegReset_n       : clock, asynchronous active-low reset
//   cmd_valid/ready          : command handshake
//   cmd_write/addr/wdata     : command fields (wdata ignored for reads)
//   rsp_valid/ready          : response handshake
//   rsp_rdata/err/timeout    : registered response fields
//   busy                     : a transfer is in progress
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA : APB request
//   PRDATA/PREADY/PSLVERR    : APB completion
// -----------------------------------------------------------------------------
module wav_apb_initiator
    import wav_apb_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                      RegClk,
    input  logic                      RegReset_n,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [APB_DATA_WIDTH-1:0] cmd_wdata,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,

    output logic                      busy,

    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_WIDTH-1:0]     PADDR,
    output logic [APB_DATA_WIDTH-1:0] PWDATA,
    input  logic [APB_DATA_WIDTH-1:0] PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    apb_state_t                state_q,  state_d;
    logic                      pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]     paddr_q,  paddr_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    apb_rsp_t                  rsp_q,    rsp_d;

    logic cmd_hs;
    logic cnt_en;
    logic tmo_expired;

    assign cmd_hs = (state_q == IDLE) && cmd_valid;
    assign cnt_en = (state_q == ACCESS) && !PREADY;

    wav_apb_timeout_cnt #(
        .MAX (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk     (RegClk),
        .rst_n   (RegReset_n),
        .clr     (cmd_hs),
        .en      (cnt_en),
        .expired (tmo_expired)
    );

    // Next state, captured request/response fields and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        rsp_d     = rsp_q;

        cmd_ready = 1'b0;
        busy      = 1'b1;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        rsp_valid = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    // Request fields only change here, so they are stable
                    // for the whole time PSEL is high.
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                PSEL    = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                // A completer answering on the last allowed cycle still wins.
                if (PREADY) begin
                    rsp_d.rdata   = pwrite_q ? '0 : PRDATA;
                    rsp_d.err     = PSLVERR;
                    rsp_d.timeout = 1'b0;
                    state_d       = RESP;
                end else if (tmo_expired) begin
                    rsp_d   = timeout_rsp();
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge RegClk or negedge RegReset_n) begin
        if (!RegReset_n) begin
            state_q  <= IDLE;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rsp_q    <= '0;
        end else begin
            state_q  <= state_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rsp_q    <= rsp_d;
        end
    end

    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_rdata   = rsp_q.rdata;
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_wav_apb_initiator.sv
// -----------------------------------------------------------------------------
// tb_wav_apb_initiator
// Transaction-level model: for each command the bench knows how many cycles
// the completer stalls and how long the host withholds rsp_ready, and from
// that derives, cycle by cycle, the expected APB and response outputs.
// -----------------------------------------------------------------------------
module tb_wav_apb_initiator;

    localparam int AW = 8;
    localparam int TO = 4;

    logic          RegClk = 1'b0;
    logic          RegReset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          busy;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    wav_apb_initiator #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .RegClk      (RegClk),
        .RegReset_n  (RegReset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    always #5 RegClk = ~RegClk;

    int n_vec  = 0;
    int n_miss = 0;

    // Expected per-cycle control outputs and held data values.
    bit            e_busy, e_psel, e_pen, e_rv;
    bit            m_pwrite;
    logic [AW-1:0] m_paddr;
    logic [31:0]   m_pwdata;
    logic [31:0]   m_rdata;
    bit            m_err, m_tmo;
    bit            chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge RegClk) begin
        if (chk_on) begin
            chk("cmd_ready",   cmd_ready,   !e_busy);
            chk("busy",        busy,        e_busy);
            chk("PSEL",        PSEL,        e_psel);
            chk("PENABLE",     PENABLE,     e_pen);
            chk("rsp_valid",   rsp_valid,   e_rv);
            chk("PWRITE",      PWRITE,      m_pwrite);
            chk("PADDR",       PADDR,       m_paddr);
            chk("PWDATA",      PWDATA,      m_pwdata);
            chk("rsp_rdata",   rsp_rdata,   m_rdata);
            chk("rsp_err",     rsp_err,     m_err);
            chk("rsp_timeout", rsp_timeout, m_tmo);
        end
    end

    task automatic set_exp(input bit b, input bit s, input bit p, input bit r);
        e_busy = b; e_psel = s; e_pen = p; e_rv = r;
    endtask

    task automatic model_reset();
        m_pwrite = 0; m_paddr = '0; m_pwdata = '0;
        m_rdata = '0; m_err = 0; m_tmo = 0;
        set_exp(0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge RegClk);
        #1;
    endtask

    // Noise the DUT must ignore in the current state.
    task automatic junk_apb();
        PREADY  = 1'($urandom_range(0, 1));
        PRDATA  = $urandom;
        PSLVERR = 1'($urandom_range(0, 1));
    endtask

    task automatic junk_cmd(input bit allow_valid);
        cmd_valid = allow_valid ? 1'($urandom_range(0, 1)) : 1'b0;
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = AW'($urandom);
        cmd_wdata = $urandom;
    endtask

    // waits: PREADY-low cycles before the completer answers.
    // dly: cycles rsp_ready is withheld once the response is up.
    // want_L >= 0 pins the model and DUT to hand-computed values.
    task automatic run_txn(input bit wr, input logic [AW-1:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input bit serr, input int waits, input int dly,
                           input int gap, input int want_L,
                           input logic [31:0] want_rdata, input bit want_err,
                           input bit want_tmo, input bit do_reset);
        int L;
        bit tmo;
        for (int g = 0; g < gap; g++) begin
            junk_cmd(0); junk_apb();
            rsp_ready = 1'($urandom_range(0, 1));
            set_exp(0, 0, 0, 0);
            step();
        end
        // Handshake cycle
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        junk_apb(); rsp_ready = 0;
        set_exp(0, 0, 0, 0);
        step();
        // SETUP
        m_pwrite = wr; m_paddr = addr; m_pwdata = wd;
        junk_cmd(1); junk_apb();
        set_exp(1, 1, 0, 0);
        step();
        tmo = (TO != 0) && (waits >= TO);
        L   = tmo ? TO : waits + 1;
        // ACCESS
        for (int a = 1; a <= L; a++) begin
            junk_cmd(1);
            if (a == waits + 1) begin
                PREADY = 1; PRDATA = rd; PSLVERR = serr;
            end else begin
                PREADY = 0; PRDATA = $urandom; PSLVERR = 1'($urandom_range(0, 1));
            end
            set_exp(1, 1, 1, 0);
            if (do_reset) begin
                #2;
                RegReset_n = 0;
                model_reset();
                #1;
                chk("rst_PSEL", PSEL, 0);
                chk("rst_PENABLE", PENABLE, 0);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_cmd_ready", cmd_ready, 1);
                cmd_valid = 0;
                step();
                step();
                RegReset_n = 1;
                return;
            end
            step();
        end
        // RESP
        if (tmo) begin
            m_rdata = '0; m_err = 1; m_tmo = 1;
        end else begin
            m_rdata = wr ? 32'h0 : rd; m_err = serr; m_tmo = 0;
        end
        if (want_L >= 0) begin
            chk("model_access_len", L, want_L);
            chk("model_rdata", m_rdata, want_rdata);
            chk("model_err", m_err, want_err);
            chk("model_tmo", m_tmo, want_tmo);
            chk("lit_rsp_valid", rsp_valid, 1);
            chk("lit_rsp_rdata", rsp_rdata, want_rdata);
            chk("lit_rsp_err", rsp_err, want_err);
            chk("lit_rsp_timeout", rsp_timeout, want_tmo);
        end
        for (int d = 0; d <= dly; d++) begin
            junk_cmd(1); junk_apb();
            rsp_ready = (d == dly);
            set_exp(1, 0, 0, 1);
            step();
        end
        // Back in IDLE
        cmd_valid = 0; rsp_ready = 0;
        set_exp(0, 0, 0, 0);
    endtask

    initial begin
        RegReset_n = 0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 0; PRDATA = '0; PREADY = 0; PSLVERR = 0;
        model_reset();
        chk_on = 1;
        #2;
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_PSEL", PSEL, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        step();
        step();
        RegReset_n = 1;
        step();

        // Zero-wait write
        run_txn(1, 8'h08, 32'h1, 32'h5555_AAAA, 0, 0, 0, 1, 1, 32'h0, 0, 0, 0);
        // Read with 3 wait states
        run_txn(0, 8'h20, 32'h0, 32'hDEAD_BEEF, 0, 3, 0, 1, 4, 32'hDEAD_BEEF, 0, 0, 0);
        // Slave error on read
        run_txn(0, 8'h10, 32'h0, 32'h1234_5678, 1, 0, 0, 0, 1, 32'h1234_5678, 1, 0, 0);
        // PREADY stuck low: timeout after 4 ACCESS cycles
        run_txn(0, 8'h30, 32'h0, 32'hCAFE_F00D, 0, 50, 0, 1, 4, 32'h0, 1, 1, 0);
        // PREADY on the 4th ACCESS cycle completes normally
        run_txn(0, 8'h34, 32'h0, 32'hA5A5_5A5A, 0, 3, 0, 0, 4, 32'hA5A5_5A5A, 0, 0, 0);
        // Response backpressure
        run_txn(1, 8'h44, 32'h0BAD_F00D, 32'hFFFF_FFFF, 0, 1, 5, 0, 2, 32'h0, 0, 0, 0);
        // Reset during ACCESS, then a normal transfer
        run_txn(0, 8'h50, 32'h0, 32'h1111_2222, 0, 2, 0, 1, -1, 32'h0, 0, 0, 1);
        run_txn(0, 8'h54, 32'h0, 32'h3333_4444, 0, 0, 0, 0, 1, 32'h3333_4444, 0, 0, 0);

        for (int i = 0; i < 200; i++) begin
            run_txn(1'($urandom_range(0, 1)), AW'($urandom), $urandom, $urandom,
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                    -1, 32'h0, 0, 0, 0);
        end

        step();
        step();
        chk_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
